// File: rtl/melody_sequencer_if.sv
// Bus between the melody sequencer, its note memory and the SoundGenerator it owns.
//
// Handshake: there is no ready/valid pair on this bus. The memory is a fixed-latency
// synchronous read: MemData_i belongs to the address MemAddress_o held one cycle earlier.
// The generator side is a start/done pulse pair: GenStart_o is a single-cycle pulse that
// also qualifies GenDuration_ms_o/GenHalfPeriod_us_o, GenDone_i is a single-cycle pulse
// ending that note, and GenFinish_o is a single-cycle pulse aborting the current note.
interface melody_sequencer_if #(
    parameter int ADDRESS_WIDTH = 8
);
    logic [ADDRESS_WIDTH-1:0] MemAddress_o;
    logic [31:0]              MemData_i;
    logic                     GenStart_o;
    logic                     GenFinish_o;
    logic [15:0]              GenDuration_ms_o;
    logic [15:0]              GenHalfPeriod_us_o;
    logic                     GenDone_i;

    // Sequencer side
    modport master (
        output MemAddress_o,
        input  MemData_i,
        output GenStart_o,
        output GenFinish_o,
        output GenDuration_ms_o,
        output GenHalfPeriod_us_o,
        input  GenDone_i
    );

    // Memory / generator side
    modport slave (
        input  MemAddress_o,
        output MemData_i,
        input  GenStart_o,
        input  GenFinish_o,
        input  GenDuration_ms_o,
        input  GenHalfPeriod_us_o,
        output GenDone_i
    );
endinterface

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a note memory from a start address, hands each note to the
// SoundGenerator and waits for its done before fetching the next one. A zero duration
// word ends the melody (or restarts it when looping); the last memory word also ends it.
module melody_sequencer #(
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Play_i,
    input  logic                     Stop_i,
    input  logic                     Loop_i,
    input  logic [ADDRESS_WIDTH-1:0] StartAddress_i,
    melody_sequencer_if.master       bus,
    output logic                     Busy_o,
    output logic                     Done_o,
    output logic [1:0]               State_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DECODE  = 2'd2,
        PLAYING = 2'd3
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = {ADDRESS_WIDTH{1'b1}};

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] start_address;
    // Set once a note has been started since the last (re)start; stops a loop on an
    // empty melody from spinning forever.
    logic                     played;

    // Debug view of the FSM state
    assign State_o = state;

    // Sequencer FSM; all outputs are registered and pulses default low every cycle
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state                  <= IDLE;
            start_address          <= '0;
            played                 <= 1'b0;
            bus.MemAddress_o       <= '0;
            bus.GenStart_o         <= 1'b0;
            bus.GenFinish_o        <= 1'b0;
            bus.GenDuration_ms_o   <= 16'd0;
            bus.GenHalfPeriod_us_o <= 16'd0;
            Busy_o                 <= 1'b0;
            Done_o                 <= 1'b0;
        end else begin
            bus.GenStart_o  <= 1'b0;
            bus.GenFinish_o <= 1'b0;
            Done_o          <= 1'b0;
            case (state)
                IDLE: begin
                    if (Play_i) begin
                        bus.MemAddress_o <= StartAddress_i;
                        start_address    <= StartAddress_i;
                        played           <= 1'b0;
                        Busy_o           <= 1'b1;
                        state            <= FETCH;
                    end
                end
                FETCH: begin
                    if (Stop_i) begin
                        Busy_o <= 1'b0;
                        Done_o <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (Stop_i) begin
                        Busy_o <= 1'b0;
                        Done_o <= 1'b1;
                        state  <= IDLE;
                    end else if (bus.MemData_i[31:16] != 16'd0) begin
                        bus.GenStart_o         <= 1'b1;
                        bus.GenDuration_ms_o   <= bus.MemData_i[31:16];
                        bus.GenHalfPeriod_us_o <= bus.MemData_i[15:0];
                        played                 <= 1'b1;
                        state                  <= PLAYING;
                    end else if (Loop_i && played) begin
                        bus.MemAddress_o <= start_address;
                        played           <= 1'b0;
                        state            <= FETCH;
                    end else begin
                        Busy_o <= 1'b0;
                        Done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                PLAYING: begin
                    if (Stop_i) begin
                        bus.GenFinish_o <= 1'b1;
                        Busy_o          <= 1'b0;
                        Done_o          <= 1'b1;
                        state           <= IDLE;
                    end else if (bus.GenDone_i) begin
                        if (bus.MemAddress_o != LAST_ADDRESS) begin
                            bus.MemAddress_o <= bus.MemAddress_o + 1'b1;
                            state            <= FETCH;
                        end else if (Loop_i && played) begin
                            // Top of memory acts as an end marker; no wrap to address 0
                            bus.MemAddress_o <= start_address;
                            played           <= 1'b0;
                            state            <= FETCH;
                        end else begin
                            Busy_o <= 1'b0;
                            Done_o <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: synchronous note ROM, auto-responding generator,
// event monitor and a melody-level reference model.
module tb_melody_sequencer;
    localparam int AW   = 8;
    localparam int LAST = (1 << AW) - 1;

    // Clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Stimulus signals
    logic          play       = 1'b0;
    logic          stop       = 1'b0;
    logic          loop_en    = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;
    logic          gen_done_auto = 1'b0;
    logic          gen_done_man  = 1'b0;
    bit            gen_auto      = 1'b1;
    int            gen_delay     = 2;

    logic [31:0] rom [0:LAST];

    melody_sequencer_if #(.ADDRESS_WIDTH(AW)) bus_if ();
    assign bus_if.GenDone_i = gen_done_auto | gen_done_man;

    melody_sequencer #(.ADDRESS_WIDTH(AW)) dut (
        .Clock          (clk),
        .Reset          (rst_n),
        .Play_i         (play),
        .Stop_i         (stop),
        .Loop_i         (loop_en),
        .StartAddress_i (start_addr),
        .bus            (bus_if.master),
        .Busy_o         (busy),
        .Done_o         (done),
        .State_o        (state_dbg)
    );

    // Synchronous note memory, one cycle read latency
    always @(posedge clk) bus_if.MemData_i <= rom[bus_if.MemAddress_o];

    // Generator model: answers each start with a done pulse gen_delay cycles later
    always begin
        @(negedge clk);
        if (gen_auto && bus_if.GenStart_o) begin
            repeat (gen_delay) @(posedge clk);
            #1;
            if (gen_auto) gen_done_auto = 1'b1;
            @(posedge clk);
            #1;
            gen_done_auto = 1'b0;
        end
    end

    // Monitor: records every note start and counts pulses
    logic [31:0] got_q[$];
    int done_cnt     = 0;
    int finish_cnt   = 0;
    int overlap_cnt  = 0;
    int done_busy_err = 0;
    bit outstanding  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 1'b0;
        end else begin
            if (bus_if.GenStart_o) begin
                if (outstanding) overlap_cnt++;
                got_q.push_back({bus_if.GenDuration_ms_o, bus_if.GenHalfPeriod_us_o});
                outstanding = 1'b1;
            end
            if (bus_if.GenFinish_o) begin
                finish_cnt++;
                outstanding = 1'b0;
            end
            if (bus_if.GenDone_i && outstanding && !bus_if.GenStart_o) outstanding = 1'b0;
            if (done) begin
                done_cnt++;
                if (busy) done_busy_err++;
            end
        end
    end

    // Scoreboard
    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    // Reference model: walk the melody as a player would, collecting up to limit notes
    task automatic model_run(input int start, input bit lp, input int limit);
        int addr;
        bit played;
        logic [31:0] w;
        exp_q.delete();
        addr   = start;
        played = 1'b0;
        while (exp_q.size() < limit) begin
            w = rom[addr];
            if (w[31:16] == 16'd0) begin
                if (lp && played) begin
                    addr   = start;
                    played = 1'b0;
                end else begin
                    break;
                end
            end else begin
                exp_q.push_back(w);
                played = 1'b1;
                if (addr == LAST) begin
                    if (lp) begin
                        addr   = start;
                        played = 1'b0;
                    end else begin
                        break;
                    end
                end else begin
                    addr++;
                end
            end
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i <= LAST; i++) rom[i] = 32'h0;
    endtask

    task automatic pulse_play(input logic [AW-1:0] a);
        start_addr = a;
        play = 1'b1;
        step();
        play = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            sample();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_starts(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            sample();
            if (got_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        sample();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (bus_if.GenStart_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", bus_if.GenStart_o); end
        checks++; if (bus_if.GenFinish_o !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", bus_if.GenFinish_o); end
        checks++; if (bus_if.MemAddress_o !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus_if.MemAddress_o); end
        checks++; if ({bus_if.GenDuration_ms_o, bus_if.GenHalfPeriod_us_o} !== 32'h0) begin errors++; $display("FAIL reset_gen_data: got %h expected 0", {bus_if.GenDuration_ms_o, bus_if.GenHalfPeriod_us_o}); end
        step();
        rst_n = 1'b1;
        repeat (3) step();
        sample();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int base, d0, ov0;
        bit ok;
        clear_rom();
        rom[0] = {16'd1, 16'd10};
        rom[1] = {16'd2, 16'd0};
        rom[2] = {16'd3, 16'd50};
        rom[3] = 32'h0000_1234;
        loop_en = 1'b0;
        gen_delay = 3;
        model_run(0, 1'b0, 16);
        base = got_q.size(); d0 = done_cnt; ov0 = overlap_cnt;
        pulse_play(8'd0);
        sample();
        sample();
        checks++; if (bus_if.GenStart_o !== 1'b0) begin errors++; $display("FAIL basic_start_early: got %b expected 0", bus_if.GenStart_o); end
        sample();
        checks++; if (bus_if.GenStart_o !== 1'b1 || {bus_if.GenDuration_ms_o, bus_if.GenHalfPeriod_us_o} !== 32'h0001_000A) begin
            errors++; $display("FAIL basic_first_start: got start=%b data=%h expected 1 0001000a", bus_if.GenStart_o, {bus_if.GenDuration_ms_o, bus_if.GenHalfPeriod_us_o});
        end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: busy=%b expected 0", busy); end
        checks++; if (got_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL basic_note_count: got %0d expected %0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL basic_note%0d: got %h expected %h", i, got_q[base + i], exp_q[i]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
        checks++; if (overlap_cnt - ov0 !== 0) begin errors++; $display("FAIL basic_start_before_done: got %0d expected 0", overlap_cnt - ov0); end
        checks++; if (done_busy_err !== 0) begin errors++; $display("FAIL basic_busy_with_done: got %0d expected 0", done_busy_err); end
    endtask

    task automatic test_empty_loop();
        int base, d0;
        clear_rom();
        rom[20] = 32'h0000_0055;
        loop_en = 1'b1;
        base = got_q.size(); d0 = done_cnt;
        pulse_play(8'd20);
        sample();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy: got %b expected 1", busy); end
        sample();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_done_early: got %b expected 0", done); end
        sample();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL empty_done_n2: got done=%b busy=%b expected 1 0", done, busy); end
        repeat (10) sample();
        checks++; if (busy !== 1'b0 || got_q.size() !== base || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL empty_settled: got busy=%b starts=%0d dones=%0d expected 0 0 1", busy, got_q.size() - base, done_cnt - d0);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_loop_stop();
        int base, d0, f0;
        bit ok;
        clear_rom();
        rom[40] = {16'd5, 16'd100};
        rom[41] = {16'd6, 16'd200};
        rom[42] = 32'h0;
        loop_en = 1'b1;
        gen_delay = 3;
        model_run(40, 1'b1, 3);
        base = got_q.size(); d0 = done_cnt; f0 = finish_cnt;
        pulse_play(8'd40);
        wait_starts(base + 3, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL loop_timeout: got %0d starts expected 3", got_q.size() - base); end
        checks++; if (bus_if.MemAddress_o !== 8'd40) begin errors++; $display("FAIL loop_restart_addr: got %0d expected 40", bus_if.MemAddress_o); end
        for (int i = 0; i < 3 && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL loop_note%0d: got %h expected %h", i, got_q[base + i], exp_q[i]); end
        end
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        sample();
        checks++; if (bus_if.GenFinish_o !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL loop_stop: got finish=%b done=%b busy=%b expected 1 1 0", bus_if.GenFinish_o, done, busy);
        end
        repeat (8) sample();
        checks++; if (finish_cnt - f0 !== 1 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL loop_stop_counts: got finish=%0d done=%0d expected 1 1", finish_cnt - f0, done_cnt - d0);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_stop_with_done();
        int base, d0, f0;
        bit ok;
        clear_rom();
        rom[60] = {16'd7, 16'd70};
        rom[61] = {16'd8, 16'd80};
        rom[62] = 32'h0;
        gen_auto = 1'b0;
        base = got_q.size(); d0 = done_cnt; f0 = finish_cnt;
        pulse_play(8'd60);
        wait_starts(base + 1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stopdone_timeout: got %0d starts expected 1", got_q.size() - base); end
        step();
        step();
        stop = 1'b1;
        gen_done_man = 1'b1;
        step();
        stop = 1'b0;
        gen_done_man = 1'b0;
        sample();
        checks++; if (bus_if.GenFinish_o !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL stopdone_pulse: got finish=%b done=%b busy=%b expected 1 1 0", bus_if.GenFinish_o, done, busy);
        end
        repeat (10) sample();
        checks++; if (bus_if.MemAddress_o !== 8'd60 || busy !== 1'b0 || got_q.size() !== base + 1) begin
            errors++; $display("FAIL stopdone_no_fetch: got addr=%0d busy=%b starts=%0d expected 60 0 1", bus_if.MemAddress_o, busy, got_q.size() - base);
        end
        checks++; if (finish_cnt - f0 !== 1 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL stopdone_counts: got finish=%0d done=%0d expected 1 1", finish_cnt - f0, done_cnt - d0);
        end
        gen_auto = 1'b1;
    endtask

    task automatic test_play_ignored_and_top();
        int base, d0;
        bit ok;
        clear_rom();
        rom[254] = {16'd9, 16'd90};
        rom[255] = {16'd10, 16'd0};
        rom[0]   = {16'd11, 16'd11};
        loop_en = 1'b0;
        gen_delay = 4;
        model_run(254, 1'b0, 16);
        base = got_q.size(); d0 = done_cnt;
        pulse_play(8'd254);
        wait_starts(base + 1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL top_timeout_start: got %0d starts expected 1", got_q.size() - base); end
        pulse_play(8'd0);
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL top_timeout_idle: busy=%b expected 0", busy); end
        checks++; if (got_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL top_note_count: got %0d expected %0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL top_note%0d: got %h expected %h", i, got_q[base + i], exp_q[i]); end
        end
        checks++; if (bus_if.MemAddress_o !== 8'd255 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL top_end: got addr=%0d dones=%0d expected 255 1", bus_if.MemAddress_o, done_cnt - d0);
        end
    endtask

    task automatic test_async_reset();
        int base, d0;
        bit ok;
        clear_rom();
        rom[80] = {16'd50, 16'd5};
        rom[81] = 32'h0;
        gen_delay = 5;
        base = got_q.size(); d0 = done_cnt;
        pulse_play(8'd80);
        wait_starts(base + 1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL areset_timeout: got %0d starts expected 1", got_q.size() - base); end
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || bus_if.GenStart_o !== 1'b0 || bus_if.GenFinish_o !== 1'b0) begin
            errors++; $display("FAIL areset_flags: got busy=%b done=%b start=%b finish=%b expected 0 0 0 0", busy, done, bus_if.GenStart_o, bus_if.GenFinish_o);
        end
        checks++; if (bus_if.MemAddress_o !== '0 || {bus_if.GenDuration_ms_o, bus_if.GenHalfPeriod_us_o} !== 32'h0) begin
            errors++; $display("FAIL areset_data: got addr=%h data=%h expected 0 0", bus_if.MemAddress_o, {bus_if.GenDuration_ms_o, bus_if.GenHalfPeriod_us_o});
        end
        step();
        step();
        rst_n = 1'b1;
        repeat (8) step();
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL areset_no_done: got %0d expected 0", done_cnt - d0); end
        base = got_q.size(); d0 = done_cnt;
        gen_delay = 2;
        pulse_play(8'd80);
        wait_idle(100, ok);
        checks++; if (!ok || got_q.size() !== base + 1 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL areset_replay: got ok=%b starts=%0d dones=%0d expected 1 1 1", ok, got_q.size() - base, done_cnt - d0);
        end else begin
            checks++; if (got_q[base] !== 32'h0032_0005) begin errors++; $display("FAIL areset_replay_note: got %h expected 00320005", got_q[base]); end
        end
    endtask

    task automatic test_random();
        int s, n, base, d0, want;
        bit ok;
        logic [15:0] dur, hp;
        for (int it = 0; it < 6; it++) begin
            clear_rom();
            s = $urandom_range(0, 200);
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                dur = 16'($urandom_range(1, 16'hFFFF));
                hp  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 16'hFFFF));
                rom[s + k] = {dur, hp};
            end
            rom[s + n] = {16'd0, 16'($urandom_range(0, 16'hFFFF))};
            gen_delay = $urandom_range(1, 5);
            loop_en = it[0];
            want = it[0] ? 2 * n + 1 : 64;
            model_run(s, it[0], want);
            base = got_q.size(); d0 = done_cnt;
            pulse_play(AW'(s));
            if (it[0]) begin
                wait_starts(base + want, 600, ok);
                checks++; if (!ok) begin errors++; $display("FAIL rand%0d_loop_timeout: got %0d starts expected %0d", it, got_q.size() - base, want); end
                step();
                stop = 1'b1;
                step();
                stop = 1'b0;
            end
            wait_idle(600, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout: busy=%b expected 0", it, busy); end
            checks++; if (got_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL rand%0d_note_count: got %0d expected %0d", it, got_q.size() - base, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
                checks++; if (got_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_note%0d: got %h expected %h", it, i, got_q[base + i], exp_q[i]); end
            end
            checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rand%0d_done_count: got %0d expected 1", it, done_cnt - d0); end
            repeat (8) step();
        end
        loop_en = 1'b0;
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL rand_start_before_done: got %0d expected 0", overlap_cnt); end
    endtask

    // Watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Test sequence and final report
    initial begin
        clear_rom();
        test_reset();
        test_basic();
        repeat (5) step();
        test_empty_loop();
        repeat (5) step();
        test_loop_stop();
        repeat (8) step();
        test_stop_with_done();
        repeat (5) step();
        test_play_ignored_and_top();
        repeat (8) step();
        test_async_reset();
        repeat (8) step();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
